// File: rtl/word_feeder_pkg.sv
// Shared definitions for the word feeder: FSM state encodings used by the
// RTL and by the bench.
package word_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : word_feeder_pkg

// File: rtl/word_feeder_if.sv
// Valid/ready word stream from the feeder (master) to its consumer (slave).
interface word_feeder_if #(
  parameter int WIDTH = 8
);

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface : word_feeder_if

// File: rtl/word_index_counter.sv
// Word index for the feeder: cleared on block capture, advanced per transfer,
// saturating at the last word so it never wraps.
module word_index_counter #(
  parameter int WORDS = 4,
  parameter int IDXW  = $clog2(WORDS)
) (
  input  logic            clk,
  input  logic            async_reset,
  input  logic            i_clr,
  input  logic            i_inc,
  output logic [IDXW-1:0] o_idx
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  logic [IDXW-1:0] r_idx;

  // Index register: clear has priority over increment.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc && (r_idx != LAST_IDX)) begin
      r_idx <= r_idx + IDXW'(1);
    end else begin
      r_idx <= r_idx;
    end
  end

  assign o_idx = r_idx;

endmodule : word_index_counter

// File: rtl/word_feeder.sv
// Captures a packed block of WORDS words on start and streams them out one per
// accepted transfer, with registered (Moore) outputs and a done pulse.
module word_feeder
  import word_feeder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   async_reset,
  input  logic                   start,
  input  logic [WIDTH*WORDS-1:0] data_input,
  output logic                   busy,
  output logic                   done,
  word_feeder_if.master          bus
);

  localparam int              IDXW     = $clog2(WORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  state_e                 r_state;
  logic [WIDTH*WORDS-1:0] r_buf;
  logic                   r_valid;
  logic [WIDTH-1:0]       r_data;
  logic                   r_last;
  logic                   r_busy;
  logic                   r_done;

  logic [IDXW-1:0]        w_idx;
  logic [IDXW-1:0]        w_idx_nxt;
  logic                   w_clr;
  logic                   w_xfer;
  logic                   w_inc;

  function automatic logic [WIDTH-1:0] pick_word(
    input logic [WIDTH*WORDS-1:0] blk,
    input logic [IDXW-1:0]        k
  );
    pick_word = blk[int'(k)*WIDTH +: WIDTH];
  endfunction

  assign w_clr     = (r_state == ST_IDLE) && start;
  assign w_xfer    = (r_state == ST_SEND) && bus.out_ready;
  assign w_inc     = w_xfer && (w_idx != LAST_IDX);
  assign w_idx_nxt = w_idx + IDXW'(1);

  word_index_counter #(
    .WORDS (WORDS),
    .IDXW  (IDXW)
  ) u_index (
    .clk         (clk),
    .async_reset (async_reset),
    .i_clr       (w_clr),
    .i_inc       (w_inc),
    .o_idx       (w_idx)
  );

  // Block FSM; outputs are computed from the next state so they leave flops,
  // which keeps out_ready off every combinational output path.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      r_state <= ST_IDLE;
      r_buf   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= ST_SEND;
            r_buf   <= data_input;
            r_valid <= 1'b1;
            r_data  <= data_input[WIDTH-1:0];
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ST_SEND: begin
          if (w_xfer && (w_idx == LAST_IDX)) begin
            r_state <= ST_DONE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_xfer) begin
            r_data  <= pick_word(r_buf, w_idx_nxt);
            r_last  <= (w_idx_nxt == LAST_IDX);
          end else begin
            r_data  <= r_data;
            r_last  <= r_last;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_data  <= '0;
          r_last  <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule : word_feeder

// File: tb/tb_word_feeder.sv
// Scoreboard bench for word_feeder: expected words are queued when a block is
// started and checked as the consumer accepts them.
module tb_word_feeder;
  import word_feeder_pkg::*;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             l;
  } exp_t;

  logic                   clk;
  logic                   async_reset;
  logic                   start;
  logic [WIDTH*WORDS-1:0] data_input;
  logic                   busy;
  logic                   done;

  word_feeder_if #(.WIDTH(WIDTH)) bus ();

  word_feeder #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk         (clk),
    .async_reset (async_reset),
    .start       (start),
    .data_input  (data_input),
    .busy        (busy),
    .done        (done),
    .bus         (bus)
  );

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   exp_done = 0;
  logic stall    = 1'b0;
  logic [WIDTH-1:0] stall_data = '0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_block(input logic [WIDTH*WORDS-1:0] blk);
    for (int k = 0; k < WORDS; k++) begin
      exp_t e;
      e.d = blk[k*WIDTH +: WIDTH];
      e.l = (k == WORDS - 1);
      q.push_back(e);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    if (!done) check_val("done_timeout", 32'd0, 32'd1);
  endtask

  // Consumer-side monitor: scoreboard pops, stall hold, idle zeroes, done pulses.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (stall) check_val("hold_data", 32'(bus.out_data), 32'(stall_data));
      if (bus.out_ready) begin
        if (q.size() == 0) begin
          check_val("extra_word", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_val("word", 32'(bus.out_data), 32'(e.d));
          check_val("last", 32'(bus.out_last), 32'(e.l));
        end
      end
    end else begin
      check_val("idle_data", 32'(bus.out_data), 32'd0);
      check_val("idle_last", 32'(bus.out_last), 32'd0);
      if (stall) check_val("stall_valid", 32'(bus.out_valid), 32'd1);
    end
    stall      = bus.out_valid && !bus.out_ready;
    stall_data = bus.out_data;
    if (prev_done) check_val("done_len", 32'(done), 32'd0);
    if (done) n_done++;
    prev_done = done;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    async_reset   = 1'b0;
    start         = 1'b0;
    data_input    = '0;
    bus.out_ready = 1'b0;

    #3;
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_data",  32'(bus.out_data),  32'd0);
    check_val("rst_busy",  32'(busy),          32'd0);
    check_val("rst_done",  32'(done),          32'd0);
    repeat (2) @(posedge clk);

    // Basic block, start presented with reset release: must be taken at first edge.
    #1;
    async_reset   = 1'b1;
    bus.out_ready = 1'b1;
    start         = 1'b1;
    data_input    = 32'hDDCCBBAA;
    push_block(32'hDDCCBBAA);
    exp_done++;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("lat_valid", 32'(bus.out_valid), 32'd1);
    check_val("lat_data",  32'(bus.out_data),  32'hAA);
    check_val("lat_busy",  32'(busy),          32'd1);
    wait_done(cyc);
    check_val("done_lat", 32'(cyc), 32'(WORDS + 1));
    check_val("done_busy", 32'(busy), 32'd1);

    // Backpressure while BB is offered.
    @(posedge clk); #1;
    start = 1'b1;
    push_block(32'hDDCCBBAA);
    exp_done++;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_val("bp_data", 32'(bus.out_data), 32'hBB);
    repeat (3) @(posedge clk);
    #1;
    check_val("bp_hold", 32'(bus.out_data), 32'hBB);
    bus.out_ready = 1'b1;
    wait_done(cyc);

    // start during SEND must not disturb the block in flight.
    @(posedge clk); #1;
    start = 1'b1;
    push_block(32'hDDCCBBAA);
    exp_done++;
    @(posedge clk); #1;
    data_input = 32'h11223344;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);

    // Reset while CC is offered aborts the block.
    @(posedge clk); #1;
    start      = 1'b1;
    data_input = 32'hDDCCBBAA;
    push_block(32'hDDCCBBAA);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_val("pre_rst_data", 32'(bus.out_data), 32'hCC);
    async_reset = 1'b0;
    q.delete();
    #1;
    check_val("arst_valid", 32'(bus.out_valid), 32'd0);
    check_val("arst_data",  32'(bus.out_data),  32'd0);
    check_val("arst_last",  32'(bus.out_last),  32'd0);
    check_val("arst_busy",  32'(busy),          32'd0);
    check_val("arst_done",  32'(done),          32'd0);
    repeat (2) @(posedge clk);
    #1;
    async_reset = 1'b1;
    start       = 1'b1;
    data_input  = 32'h04030201;
    push_block(32'h04030201);
    exp_done++;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("post_rst_data", 32'(bus.out_data), 32'h01);
    wait_done(cyc);
    check_val("post_rst_lat", 32'(cyc), 32'(WORDS + 1));

    // start held high: back-to-back blocks, busy low one cycle between them.
    @(posedge clk); #1;
    start      = 1'b1;
    data_input = 32'h44332211;
    for (int b = 0; b < 3; b++) push_block(32'h44332211);
    exp_done += 3;
    @(posedge clk);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check_val($sformatf("b2b_busy%0d", k), 32'(busy), 32'((k % (WORDS + 2)) != 0));
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);

    check_val("done_count", 32'(n_done), 32'(exp_done));
    check_val("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_word_feeder
